// File: rtl/tag_sync_pkg.sv
// tag_sync_pkg: shared state codes, GPIO masks and phase-length helpers for the tag hop-sync anchor.
package tag_sync_pkg;
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_SYNC = 3'd2,
        ST_LOC_SYNCH = 3'd3,
        ST_HOP_SYNCH = 3'd4,
        ST_HOP_TX    = 3'd5
    } tx_state_e;

    localparam int unsigned GPIO_TAG_SYNC_OUT = 'h001;
    localparam int unsigned GPIO_TAG_RX_OUT   = 'h010;
    localparam int unsigned GPIO_SYNC_TRIG    = 'h004;
    localparam int unsigned GPIO_SCAN         = 'h040;
    localparam int unsigned GPIO_DDR          = 'h044;

    localparam int unsigned LOC_MUL      = 1;
    localparam int unsigned HOP_SCAN_MUL = 1;
    localparam int unsigned HOP_NORM_MUL = 3;
    localparam int unsigned TX_MUL       = 2;
    localparam int unsigned TX_ADD       = 1;

    function automatic int unsigned phase_len(int unsigned mul, int unsigned add, int unsigned n);
        return mul * n + add;
    endfunction
endpackage

// File: rtl/tag_tx_gpio_if.sv
// tag_tx_gpio_if: 2-FF synchronizer and registered rising-edge detect on tag feedback, registered GPIO drive.
import tag_sync_pkg::*;

module tag_tx_gpio_if #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] fp_gpio_in,
    input  logic         trig_d,
    input  logic         scan_d,
    output logic         sync_rise,
    output logic         rx_sync,
    output logic [W-1:0] fp_gpio_out,
    output logic [W-1:0] fp_gpio_ddr
);
    logic [W-1:0] s1_q, s2_q, gpio_d, gpio_q;
    logic         s3_q, rise_d, rise_q, sync_lvl;

    always_comb begin
        sync_lvl = |(s2_q & W'(GPIO_TAG_SYNC_OUT));
        rx_sync  = |(s2_q & W'(GPIO_TAG_RX_OUT));
        rise_d   = sync_lvl & ~s3_q;
        gpio_d   = (trig_d ? W'(GPIO_SYNC_TRIG) : '0) | (scan_d ? W'(GPIO_SCAN) : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= 1'b0;
            rise_q <= 1'b0;
            gpio_q <= '0;
        end else begin
            s1_q   <= fp_gpio_in;
            s2_q   <= s1_q;
            s3_q   <= sync_lvl;
            rise_q <= rise_d;
            gpio_q <= gpio_d;
        end
    end

    assign sync_rise   = rise_q;
    assign fp_gpio_out = gpio_q;
    assign fp_gpio_ddr = W'(GPIO_DDR);
endmodule

// File: rtl/tag_tx_ctrl_anc.sv
// tag_tx_ctrl_anc: anchor-side hop-sync controller; triggers the tag, tracks its sync phases, gates TX IQ.
// Define TAG_TX_CTRL_PILOT_EN to transmit a constant I pilot during LOC_SYNCH.
import tag_sync_pkg::*;

module tag_tx_ctrl_anc #(
    parameter int DATA_WIDTH     = 16,
    parameter int GPIO_REG_WIDTH = 12,
    parameter int CNT_WIDTH      = 16,
    parameter int SYNC_SIG_N     = 8192,
    parameter int TRIG_LEN       = 16,
    parameter int TIMEOUT        = 65535,
    parameter int LINK_CHK_OFS   = 64,
    parameter logic signed [DATA_WIDTH-1:0] PILOT_AMP = 16'sd32000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      scan_mode,
    input  logic [DATA_WIDTH-1:0]     tx_i_in,
    input  logic [DATA_WIDTH-1:0]     tx_q_in,
    input  logic [GPIO_REG_WIDTH-1:0] fp_gpio_in,
    output logic [GPIO_REG_WIDTH-1:0] fp_gpio_out,
    output logic [GPIO_REG_WIDTH-1:0] fp_gpio_ddr,
    output logic [DATA_WIDTH-1:0]     tx_i_out,
    output logic [DATA_WIDTH-1:0]     tx_q_out,
    output logic                      tx_valid,
    output logic [2:0]                tx_state,
    output logic [CNT_WIDTH-1:0]      counter,
    output logic                      busy,
    output logic                      done,
    output logic                      err_timeout,
    output logic                      err_link
);
`ifdef TAG_TX_CTRL_PILOT_EN
    localparam logic PILOT_EN = 1'b1;
`else
    localparam logic PILOT_EN = 1'b0;
`endif
    localparam logic [CNT_WIDTH-1:0] TRIG_L = CNT_WIDTH'(TRIG_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] TO_L   = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] LOC_L  = CNT_WIDTH'(phase_len(LOC_MUL, 0, SYNC_SIG_N) - 1);
    localparam logic [CNT_WIDTH-1:0] HOPS_L = CNT_WIDTH'(phase_len(HOP_SCAN_MUL, 0, SYNC_SIG_N) - 1);
    localparam logic [CNT_WIDTH-1:0] HOPN_L = CNT_WIDTH'(phase_len(HOP_NORM_MUL, 0, SYNC_SIG_N) - 1);
    localparam logic [CNT_WIDTH-1:0] TX_L   = CNT_WIDTH'(phase_len(TX_MUL, TX_ADD, SYNC_SIG_N) - 1);
    // HOP_TX counts down from TX_L, so count-up index LINK_CHK_OFS maps to this counter value
    localparam logic [CNT_WIDTH-1:0] LINK_C = TX_L - CNT_WIDTH'(LINK_CHK_OFS);

    tx_state_e             state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  scan_q, scan_d, err_to_q, err_to_d, err_link_q, err_link_d;
    logic [DATA_WIDTH-1:0] tx_i_q, tx_i_d, tx_q_q, tx_q_d;
    logic                  tx_valid_q, tx_valid_d, last, sync_rise, rx_sync, hop_tx_d, pilot_d;

    always_comb begin
        last       = cnt_q == '0;
        state_d    = state_q;
        cnt_d      = last ? cnt_q : cnt_q - CNT_WIDTH'(1);
        scan_d     = scan_q;
        err_to_d   = err_to_q;
        err_link_d = err_link_q;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d    = ST_TRIG;
                cnt_d      = TRIG_L;
                scan_d     = scan_mode;
                err_to_d   = 1'b0;
                err_link_d = 1'b0;
            end
            ST_TRIG: if (last) begin
                state_d = ST_WAIT_SYNC;
                cnt_d   = TO_L;
            end
            ST_WAIT_SYNC: if (sync_rise) begin
                state_d = ST_LOC_SYNCH;
                cnt_d   = LOC_L;
            end else if (last) begin
                state_d  = ST_IDLE;
                err_to_d = 1'b1;
            end
            ST_LOC_SYNCH: if (last) begin
                state_d = ST_HOP_SYNCH;
                cnt_d   = scan_q ? HOPS_L : HOPN_L;
            end
            ST_HOP_SYNCH: if (last) begin
                state_d = ST_HOP_TX;
                cnt_d   = TX_L;
            end
            ST_HOP_TX: begin
                if (cnt_q == LINK_C && !rx_sync) err_link_d = 1'b1;
                if (last) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        hop_tx_d   = state_d == ST_HOP_TX;
        pilot_d    = PILOT_EN && state_d == ST_LOC_SYNCH;
        tx_valid_d = hop_tx_d | pilot_d;
        tx_i_d     = hop_tx_d ? tx_i_in : (pilot_d ? PILOT_AMP : '0);
        tx_q_d     = hop_tx_d ? tx_q_in : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            scan_q     <= 1'b0;
            err_to_q   <= 1'b0;
            err_link_q <= 1'b0;
            tx_i_q     <= '0;
            tx_q_q     <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            scan_q     <= scan_d;
            err_to_q   <= err_to_d;
            err_link_q <= err_link_d;
            tx_i_q     <= tx_i_d;
            tx_q_q     <= tx_q_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    tag_tx_gpio_if #(.W(GPIO_REG_WIDTH)) u_gpio (
        .clk        (clk),
        .reset      (reset),
        .fp_gpio_in (fp_gpio_in),
        .trig_d     (state_d == ST_TRIG),
        .scan_d     (state_d != ST_IDLE && scan_d),
        .sync_rise  (sync_rise),
        .rx_sync    (rx_sync),
        .fp_gpio_out(fp_gpio_out),
        .fp_gpio_ddr(fp_gpio_ddr)
    );

    assign tx_i_out    = tx_i_q;
    assign tx_q_out    = tx_q_q;
    assign tx_valid    = tx_valid_q;
    assign tx_state    = state_q;
    assign counter     = cnt_q;
    assign busy        = state_q != ST_IDLE;
    assign done        = state_q == ST_HOP_TX && last;
    assign err_timeout = err_to_q;
    assign err_link    = err_link_q;
endmodule

// File: tb/tb_tag_tx_ctrl_anc.sv
// tb_tag_tx_ctrl_anc: phase-timeline model of the anchor controller checked every cycle, plus literal duration checks.
import tag_sync_pkg::*;

module tb_tag_tx_ctrl_anc;
    localparam int N = 8, TL = 4, TO = 20, OFS = 3;
`ifdef TAG_TX_CTRL_PILOT_EN
    localparam bit PILOT = 1'b1;
`else
    localparam bit PILOT = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, scan_mode = 1'b0;
    logic [15:0] tx_i_in = 16'h0000, tx_q_in = 16'h8000;
    logic [11:0] fp_gpio_in = 12'h000;
    logic [11:0] fp_gpio_out, fp_gpio_ddr;
    logic [15:0] tx_i_out, tx_q_out, counter;
    logic [2:0]  tx_state;
    logic        tx_valid, busy, done, err_timeout, err_link;

    always #5 clk = ~clk;

    tag_tx_ctrl_anc #(
        .SYNC_SIG_N(N), .TRIG_LEN(TL), .TIMEOUT(TO), .LINK_CHK_OFS(OFS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .scan_mode(scan_mode),
        .tx_i_in(tx_i_in), .tx_q_in(tx_q_in), .fp_gpio_in(fp_gpio_in),
        .fp_gpio_out(fp_gpio_out), .fp_gpio_ddr(fp_gpio_ddr),
        .tx_i_out(tx_i_out), .tx_q_out(tx_q_out), .tx_valid(tx_valid),
        .tx_state(tx_state), .counter(counter), .busy(busy), .done(done),
        .err_timeout(err_timeout), .err_link(err_link)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", n, a, e, $time);
        end
    endtask

    // Model: each phase is a window [t0, t0+len) of edge numbers; the tag's
    // feedback reaches the controller through a fixed input history.
    int          k = 0, ph = 0, t0 = 0, len = 0;
    bit          mvalid = 0, mscan = 0, m_to = 0, m_lk = 0, ended;
    logic [4:0]  hs = '0;
    logic [2:0]  hr = '0;
    logic [31:0] e_cnt, e_gpio;
    logic [15:0] e_i, e_q;
    logic        e_val, e_done;

    task automatic enter(input int p, input int l);
        ph = p;
        t0 = k;
        len = l;
    endtask

    always @(posedge clk) begin
        k++;
        hs = {hs[3:0], fp_gpio_in[0]};
        hr = {hr[1:0], fp_gpio_in[4]};
        ended = (k == t0 + len);
        if (reset) begin
            mvalid = 1; ph = 0; hs = '0; hr = '0; m_to = 0; m_lk = 0; mscan = 0;
        end else if (ph == 0) begin
            if (start) begin enter(1, TL); mscan = scan_mode; m_to = 0; m_lk = 0; end
        end else begin
            case (ph)
                1: if (ended) enter(2, TO);
                2: if (hs[3] && !hs[4]) enter(3, N); else if (ended) begin ph = 0; m_to = 1; end
                3: if (ended) enter(4, mscan ? N : 3 * N);
                4: if (ended) enter(5, 2 * N + 1);
                default: begin
                    if (k - 1 - t0 == OFS && !hr[2]) m_lk = 1;
                    if (ended) ph = 0;
                end
            endcase
        end
        e_cnt  = ph == 0 ? 0 : t0 + len - 1 - k;
        e_done = ph == 5 && e_cnt == 0;
        e_gpio = (ph == 1 ? 32'h004 : 32'h0) | (ph != 0 && mscan ? 32'h040 : 32'h0);
        e_val  = ph == 5 || (PILOT && ph == 3);
        e_i    = ph == 5 ? tx_i_in : (PILOT && ph == 3 ? 16'd32000 : 16'd0);
        e_q    = ph == 5 ? tx_q_in : 16'd0;
    end

    string       lit_n = "";
    logic [31:0] lit_a = 0, lit_e = 0;
    bit          lit_go = 0, clr = 0, lk_seen = 0;
    int          n_trig, n_wait, n_loc, n_hops, n_tx, n_val, n_done, n_scan, lk_cnt;

    always @(negedge clk) begin
        if (mvalid) begin
            chk("state", 32'(tx_state), 32'(ph));
            chk("counter", 32'(counter), e_cnt);
            chk("busy", 32'(busy), 32'(ph != 0));
            chk("done", 32'(done), 32'(e_done));
            chk("err_timeout", 32'(err_timeout), 32'(m_to));
            chk("err_link", 32'(err_link), 32'(m_lk));
            chk("gpio_out", 32'(fp_gpio_out), e_gpio);
            chk("gpio_ddr", 32'(fp_gpio_ddr), 32'h044);
            chk("tx_valid", 32'(tx_valid), 32'(e_val));
            chk("tx_i", 32'(tx_i_out), 32'(e_i));
            chk("tx_q", 32'(tx_q_out), 32'(e_q));
        end
        if (lit_go) chk(lit_n, lit_a, lit_e);
        if (clr) begin
            n_trig = 0; n_wait = 0; n_loc = 0; n_hops = 0; n_tx = 0;
            n_val = 0; n_done = 0; n_scan = 0; lk_seen = 0; lk_cnt = -1;
        end else begin
            n_trig += int'(fp_gpio_out[2]);
            n_scan += int'(fp_gpio_out[6]);
            n_wait += int'(tx_state == ST_WAIT_SYNC);
            n_loc  += int'(tx_state == ST_LOC_SYNCH);
            n_hops += int'(tx_state == ST_HOP_SYNCH);
            n_tx   += int'(tx_state == ST_HOP_TX);
            n_val  += int'(tx_valid);
            n_done += int'(done);
            if (err_link && !lk_seen) begin lk_seen = 1; lk_cnt = int'(counter); end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        tx_i_in = tx_i_in + 16'h0123;
        tx_q_in = tx_q_in - 16'h0011;
    endtask

    task automatic lit(input string n, input logic [31:0] a, input logic [31:0] e);
        lit_n = n; lit_a = a; lit_e = e; lit_go = 1;
        @(negedge clk);
        #1 lit_go = 0;
    endtask

    task automatic clear();
        clr = 1;
        @(negedge clk);
        #1 clr = 0;
    endtask

    task automatic wait_st(input logic [2:0] s, input int budget);
        for (int i = 0; i < budget && tx_state != s; i++) tick();
        if (tx_state != s) lit("wait_bound", 32'(tx_state), 32'(s));
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        if (!done) lit("done_bound", 32'(done), 32'd1);
    endtask

    task automatic run(input bit sc, input bit rx, input bit poke);
        clear();
        fp_gpio_in = rx ? 12'h010 : 12'h000;
        scan_mode = sc; start = 1; tick(); start = 0; scan_mode = 0;
        wait_st(ST_WAIT_SYNC, 20);
        repeat (5) tick();
        fp_gpio_in[0] = 1'b1;
        if (poke) begin
            wait_st(ST_HOP_SYNCH, 40);
            tick(); tick(); start = 1; tick(); start = 0;
        end
        wait_done(100);
        start = 1; tick(); start = 0;
        fp_gpio_in[0] = 1'b0;
        lit("drop_start", 32'(tx_state), 32'(ST_IDLE));
    endtask

    initial begin
        repeat (3) tick();
        lit("rst_state", 32'(tx_state), 0);
        lit("rst_outs", {fp_gpio_out, tx_valid, done, err_timeout, err_link}, 0);
        lit("rst_ddr", 32'(fp_gpio_ddr), 32'h044);
        reset = 0;
        tick();

        run(0, 1, 0);
        lit("norm_trig", n_trig, 4);
        lit("norm_wait", n_wait, 9);
        lit("norm_loc", n_loc, 8);
        lit("norm_hops", n_hops, 24);
        lit("norm_tx", n_tx, 17);
        lit("norm_valid", n_val, PILOT ? 25 : 17);
        lit("norm_done", n_done, 1);
        lit("norm_scan", n_scan, 0);

        run(1, 1, 0);
        lit("scan_hops", n_hops, 8);
        lit("scan_pin", n_scan, 46);
        lit("scan_done", n_done, 1);

        clear();
        fp_gpio_in = 12'h000;
        start = 1; tick(); start = 0;
        wait_st(ST_WAIT_SYNC, 20);
        wait_st(ST_IDLE, 40);
        lit("to_flag", 32'(err_timeout), 1);
        lit("to_wait", n_wait, 20);
        lit("to_valid", n_val, 0);

        run(0, 0, 0);
        lit("link_flag", 32'(err_link), 1);
        lit("link_cnt", lk_cnt, 12);
        fp_gpio_in = 12'h010;
        start = 1; tick(); start = 0;
        lit("link_clr", 32'(err_link), 0);
        wait_st(ST_WAIT_SYNC, 20);
        repeat (5) tick();
        fp_gpio_in[0] = 1'b1;
        wait_st(ST_HOP_TX, 100);
        repeat (3) tick();
        reset = 1; tick();
        lit("midrst_state", {13'd0, tx_state, counter}, 0);
        lit("midrst_outs", {fp_gpio_out, tx_valid, done, err_timeout, err_link}, 0);
        lit("midrst_iq", {tx_i_out, tx_q_out}, 0);
        reset = 0; fp_gpio_in = 12'h010; tick();

        run(0, 1, 1);
        lit("poke_hops", n_hops, 24);
        lit("poke_trig", n_trig, 4);
        lit("poke_done", n_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
